// File: rtl/pipe_skid_stage.sv
// Two-entry registered valid/ready stage with flush.
// i_ready depends only on state, so o_ready never reaches it combinationally.
module pipe_skid_stage #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  i_valid,
   output logic                  i_ready,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [1:0]            count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] main_q;
   logic [DATA_WIDTH-1:0] skid_q;
   logic                  i_fire;
   logic                  o_fire;

   assign i_ready = (state != FULL);
   assign o_valid = (state != EMPTY);
   assign o_data  = main_q;
   assign i_fire  = i_valid & i_ready;
   assign o_fire  = o_valid & o_ready;

   always_comb begin
      count = 2'd0;
      case (state)
         BUSY:    count = 2'd1;
         FULL:    count = 2'd2;
         default: count = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (i_fire) begin
                  main_q <= i_data;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (i_fire && o_fire) begin
                  main_q <= i_data;
               end else if (i_fire) begin
                  skid_q <= i_data;
                  state  <= FULL;
               end else if (o_fire) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (o_fire) begin
                  main_q <= skid_q;
                  state  <= BUSY;
               end
            end
            // 2'b11 is unreachable; fall back to empty
            default: state <= EMPTY;
         endcase
      end
   end

endmodule
